riscv_fetch_unit: RTL and testbench
===================================

// Module: riscv_fetch_unit
// PURPOSE
//  Instruction fetch stage feeding the riscv decode/execute core. Keeps a sequential fetch PC and
//  issues word requests to a registered-response instruction memory. Buffers returned words with
//  their PCs in a prefetch FIFO and presents them to the core over a valid/ready handshake.
//  Accepts redirects (jumps/branches) from the core; on a redirect it flushes the FIFO and drops
//  stale in-flight responses.
// PARAMETERS
//  XLEN      32  address/PC width
//  DEPTH     4   prefetch FIFO entries; power of 2, >=2; also max outstanding+buffered words
//  RESET_PC  0   first fetch address after reset; word aligned
// PORTS
//  clk             in   1     clock, rising edge
//  rst_n           in   1     asynchronous active-low reset
//  imem_req_valid  out  1     fetch request valid
//  imem_req_ready  in   1     memory accepts request
//  imem_req_addr   out  XLEN  byte address of requested word, [1:0]==0
//  imem_rsp_valid  in   1     response word valid (no backpressure, in order, >=1 cycle after accept)
//  imem_rsp_data   in   32    response instruction word
//  redirect_valid  in   1     core requests fetch restart
//  redirect_pc     in   XLEN  restart address
//  inst_valid      out  1     FIFO head valid
//  inst_ready      in   1     core consumes head
//  inst_data       out  32    head instruction
//  inst_pc         out  XLEN  PC of head instruction
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, fetch_pc=rsp_pc=RESET_PC, outstanding=0, FIFO empty,
//    storage cleared. Outputs: imem_req_valid=0, imem_req_addr=RESET_PC, inst_valid=0,
//    inst_data=0, inst_pc=0. Takes effect immediately, mid-operation included; in-flight
//    responses after reset are not tracked.
//  - FSM states:
//    IDLE  -> FETCH on the first clock after rst_n rises.
//    FETCH -> FLUSH on redirect_valid when outstanding (after this cycle's response) >0;
//             otherwise stays in FETCH.
//    FLUSH -> FETCH when outstanding reaches 0, including a final stale response arriving
//             this cycle. A redirect while in FLUSH updates the PCs and stays in FLUSH.
//  - Request: imem_req_valid = (state==FETCH) && !redirect_valid && (outstanding+count < DEPTH).
//    imem_req_addr=fetch_pc. On accept (valid&&ready): fetch_pc+=4, outstanding+=1.
//  - Response in FETCH: push {rsp_pc, rsp_data}, rsp_pc+=4, outstanding-=1. Credit rule
//    guarantees no overflow.
//  - Response in FLUSH, or in the redirect cycle: dropped, outstanding-=1, no push.
//  - Output: inst_valid = count!=0. inst_data/inst_pc come from registered FIFO head.
//    Latency: response at edge t is visible on inst_* after edge t (1 cycle). Pop on
//    inst_valid&&inst_ready. Push and pop in the same cycle leave count unchanged. A popped
//    entry frees a credit from the next cycle.
//  - Redirect (priority over everything): FIFO cleared (count=0, inst_valid=0 next cycle).
//    A head handshaken in the same cycle counts as consumed.
//    fetch_pc = rsp_pc = {redirect_pc[XLEN-1:2],2'b00} (misaligned low bits forced to 0).
//    No request is issued in the redirect cycle.
//  - Arithmetic: all PC increments are modulo 2^XLEN (0xFFFFFFFC+4 -> 0).
//    outstanding and count are clog2(DEPTH)+1 bits wide and never exceed DEPTH.
//  - Empty FIFO with inst_ready=1: no effect. Full FIFO: req_valid=0, responses cannot arrive.
// TESTING
//  1 Reset release, memory latency 1, req_ready=1, inst_ready=1 -> first request on the 2nd
//    cycle at 0x0; inst_pc 0,4,8,C... one per cycle thereafter, data matches memory image.
//  2 inst_ready=0 -> exactly 4 requests issued, then req_valid=0. Raise inst_ready -> pcs
//    0,4,8,C in order, fetching resumes at 0x10, no gaps or duplicates.
//  3 Memory latency 3, redirect_pc=0x40 with 2 outstanding -> FIFO empty next cycle, FLUSH
//    for 2 responses (both dropped), next inst_pc=0x40 with 0x40's word.
//  4 redirect_pc=0x43 with 0 outstanding -> stays FETCH, next request addr=0x40,
//    inst_pc=0x40.
//  5 RESET_PC=0xFFFFFFF8 -> inst_pc F8, FC, then 0x00000000, 0x4.
//  6 Pull rst_n low mid-stream between edges -> inst_valid/imem_req_valid=0 immediately;
//    after release, fetching restarts at RESET_PC and late responses do not corrupt order.

Source files
------------

// File: rtl/riscv_fetch_unit_if.sv
// Fetch-stage bundle: instruction memory request/response, core redirect and
// the instruction handshake toward decode. master = fetch unit side.
interface riscv_fetch_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            inst_valid;
    logic            inst_ready;
    logic [31:0]     inst_data;
    logic [XLEN-1:0] inst_pc;

    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, inst_ready
    );
endinterface

// File: rtl/riscv_fetch_unit.sv
// Instruction fetch stage: sequential PC, credit-limited memory requests,
// prefetch FIFO toward the core, redirect with flush of stale responses.
module riscv_fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input logic                clk,
    input logic                rst_n,
    riscv_fetch_unit_if.master bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_t;

    state_t          state;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] rsp_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   count;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [31:0]     data_mem [DEPTH];
    logic [XLEN-1:0] pc_mem   [DEPTH];

    logic            req_valid;
    logic            accept;
    logic            pop;
    logic            rsp_live;
    logic            push;
    logic [CW:0]     credit_use;
    logic [CW-1:0]   out_next;
    logic [XLEN-1:0] redir_pc;

    always_comb begin
        credit_use = {1'b0, outstanding} + {1'b0, count};
        req_valid  = (state == FETCH) && !bus.redirect_valid
                     && (credit_use < (CW+1)'(DEPTH));
        accept     = req_valid && bus.imem_req_ready;
        pop        = (count != '0) && bus.inst_ready;
        // Responses with nothing tracked in flight predate the last reset.
        rsp_live   = bus.imem_rsp_valid && (outstanding != '0);
        push       = rsp_live && (state == FETCH) && !bus.redirect_valid;
        out_next   = outstanding + CW'(accept) - CW'(rsp_live);
        redir_pc   = {bus.redirect_pc[XLEN-1:2], 2'b00};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_mem[i] <= '0;
                pc_mem[i]   <= '0;
            end
        end else begin
            outstanding <= out_next;
            unique case (state)
                IDLE:    state <= FETCH;
                FETCH:   if (bus.redirect_valid && (out_next != '0)) state <= FLUSH;
                FLUSH:   if (out_next == '0) state <= FETCH;
                default: state <= IDLE;
            endcase
            if (bus.redirect_valid) begin
                fetch_pc <= redir_pc;
                rsp_pc   <= redir_pc;
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (accept) fetch_pc <= fetch_pc + XLEN'(4);
                if (push) begin
                    data_mem[wr_ptr] <= bus.imem_rsp_data;
                    pc_mem[wr_ptr]   <= rsp_pc;
                    wr_ptr           <= wr_ptr + AW'(1);
                    rsp_pc           <= rsp_pc + XLEN'(4);
                end
                if (pop) rd_ptr <= rd_ptr + AW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fetch_pc;
    assign bus.inst_valid     = (count != '0);
    assign bus.inst_data      = data_mem[rd_ptr];
    assign bus.inst_pc        = pc_mem[rd_ptr];
endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Bench for riscv_fetch_unit: memory model with configurable latency and an
// instruction-stream reference (expected next PC/word) checked on every handshake.
module tb_riscv_fetch_unit;
    localparam logic [31:0] RST_PC = 32'h0;
    localparam logic [31:0] NONE   = 32'hDEAD_BEEF;

    logic clk;
    logic rst_n;

    riscv_fetch_unit_if #(.XLEN(32)) bus ();

    riscv_fetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(RST_PC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } pend_t;

    typedef struct {
        logic [31:0] rpc;
        logic [31:0] exp_pc;
        int unsigned exp_gap;
    } vec_t;

    pend_t       pend[$];
    int          n_pass;
    int          n_total;
    int unsigned cyc_n;
    int unsigned lat;
    bit          jitter;
    logic [31:0] exp_pc;
    logic [31:0] req_exp;
    bit          post_redir;
    bit          first_req_chk;
    int unsigned n_req;
    int unsigned n_pop;
    bit          got_req;
    bit          got_pop;
    logic [31:0] first_req_addr;
    logic [31:0] first_pop_pc;
    int unsigned first_req_cyc;
    int unsigned redir_cyc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_3C3C;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    endtask

    // One clock cycle: drive at the falling edge, check just after it.
    task automatic cyc(input bit redir, input logic [31:0] rpc, input bit rqr, input bit inr);
        int unsigned due;
        logic [31:0] al;
        @(negedge clk);
        if (pend.size() != 0 && pend[0].due == cyc_n) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_word(pend[0].addr);
            pend.delete(0);
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = $urandom;
        end
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        bus.imem_req_ready = rqr;
        bus.inst_ready     = inr;
        #1;
        if (first_req_chk) begin
            chk("first_req_valid", 32'(bus.imem_req_valid), 32'd1);
            chk("first_req_addr", bus.imem_req_addr, RST_PC);
            first_req_chk = 1'b0;
        end
        if (redir) chk("no_req_on_redirect", 32'(bus.imem_req_valid), 32'd0);
        if (post_redir) chk("empty_after_redirect", 32'(bus.inst_valid), 32'd0);
        if (bus.imem_req_valid && bus.imem_req_ready) begin
            chk("req_addr", bus.imem_req_addr, req_exp);
            if (!got_req) begin
                got_req        = 1'b1;
                first_req_addr = bus.imem_req_addr;
                first_req_cyc  = cyc_n;
            end
            req_exp = req_exp + 32'd4;
            due = cyc_n + (jitter ? $urandom_range(1, 4) : lat);
            if (pend.size() != 0 && due <= pend[$].due) due = pend[$].due + 1;
            pend.push_back('{bus.imem_req_addr, due});
            n_req++;
        end
        if (bus.inst_valid && bus.inst_ready) begin
            chk("inst_pc", bus.inst_pc, exp_pc);
            chk("inst_data", bus.inst_data, mem_word(exp_pc));
            if (!got_pop) begin
                got_pop      = 1'b1;
                first_pop_pc = bus.inst_pc;
            end
            exp_pc = exp_pc + 32'd4;
            n_pop++;
        end
        if (redir) begin
            al        = {rpc[31:2], 2'b00};
            exp_pc    = al;
            req_exp   = al;
            got_req   = 1'b0;
            got_pop   = 1'b0;
            first_req_addr = NONE;
            first_pop_pc   = NONE;
            redir_cyc = cyc_n;
        end
        post_redir = redir;
        cyc_n++;
    endtask

    // Asserts reset between edges, feeds stale responses, releases mid-cycle.
    task automatic apply_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("rst_req_addr", bus.imem_req_addr, RST_PC);
        chk("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
        chk("rst_inst_data", bus.inst_data, 32'd0);
        chk("rst_inst_pc", bus.inst_pc, 32'd0);
        pend.delete();
        bus.redirect_valid = 1'b0;
        bus.imem_req_ready = 1'b1;
        bus.inst_ready     = 1'b1;
        repeat (2) begin
            @(negedge clk);
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = $urandom;
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = $urandom;
        #1;
        chk("idle_no_req", 32'(bus.imem_req_valid), 32'd0);
        exp_pc = RST_PC;
        req_exp = RST_PC;
        post_redir = 1'b0;
        first_req_chk = 1'b1;
        n_req = 0;
        n_pop = 0;
        got_req = 1'b0;
        got_pop = 1'b0;
        first_req_addr = NONE;
        first_pop_pc = NONE;
    endtask

    initial begin
        vec_t vecs[4];
        int unsigned pop_base;
        vecs[0] = '{32'h0000_0043, 32'h0000_0040, 1};
        vecs[1] = '{32'h0000_0100, 32'h0000_0100, 1};
        vecs[2] = '{32'hFFFF_FFFB, 32'hFFFF_FFF8, 1};
        vecs[3] = '{32'h0000_07FE, 32'h0000_07FC, 1};

        n_pass = 0; n_total = 0; cyc_n = 0; lat = 1; jitter = 1'b0;
        rst_n = 1'b1;
        bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0;
        bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.inst_ready = 1'b0;

        // Streaming at latency 1: one instruction per cycle after warm-up.
        apply_reset();
        repeat (12) cyc(1'b0, '0, 1'b1, 1'b1);
        chk("t1_reqs", 32'(n_req), 32'd12);
        chk("t1_pops", 32'(n_pop), 32'd10);

        // Core stalled: credits cap requests at the FIFO depth.
        apply_reset();
        repeat (10) cyc(1'b0, '0, 1'b1, 1'b0);
        chk("t2_reqs_capped", 32'(n_req), 32'd4);
        chk("t2_req_low", 32'(bus.imem_req_valid), 32'd0);
        got_req = 1'b0;
        first_req_addr = NONE;
        repeat (10) cyc(1'b0, '0, 1'b1, 1'b1);
        chk("t2_first_pop", first_pop_pc, 32'h0);
        chk("t2_resume_addr", first_req_addr, 32'h10);

        // Redirect with responses in flight at latency 3.
        apply_reset();
        lat = 3;
        repeat (8) cyc(1'b0, '0, 1'b1, 1'b1);
        cyc(1'b1, 32'h40, 1'b1, 1'b1);
        repeat (14) cyc(1'b0, '0, 1'b1, 1'b1);
        chk("t3_first_pop", first_pop_pc, 32'h40);
        chk("t3_first_req", first_req_addr, 32'h40);

        // Table: redirects with nothing outstanding, misaligned and wrapping targets.
        lat = 1;
        for (int i = 0; i < 4; i++) begin
            repeat (4) cyc(1'b0, '0, 1'b0, 1'b1);
            cyc(1'b1, vecs[i].rpc, 1'b1, 1'b1);
            repeat (10) cyc(1'b0, '0, 1'b1, 1'b1);
            chk("tbl_req_addr", first_req_addr, vecs[i].exp_pc);
            chk("tbl_req_gap", 32'(first_req_cyc - redir_cyc), 32'(vecs[i].exp_gap));
            chk("tbl_pop_pc", first_pop_pc, vecs[i].exp_pc);
        end

        // Randomized traffic against the stream model.
        jitter = 1'b1;
        pop_base = n_pop;
        for (int i = 0; i < 1500; i++) begin
            cyc(($urandom_range(0, 99) < 4), $urandom,
                ($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 70));
        end
        chk("rand_progress", 32'(n_pop - pop_base > 100), 32'd1);

        // Reset mid-stream with responses still in flight.
        jitter = 1'b0;
        lat = 2;
        apply_reset();
        repeat (12) cyc(1'b0, '0, 1'b1, 1'b1);
        chk("t6_first_pop", first_pop_pc, RST_PC);
        chk("t6_pops", 32'(n_pop >= 8), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
